// File: rtl/ucode_sequencer_if.sv
// ROM fetch, port banks and status of the microcode sequencer, bundled for one port connection.
// master is the sequencer side; slave is the ROM/datapath side.
interface ucode_sequencer_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_IN   = 4,
   parameter int unsigned N_OUT  = 4
);
   logic                    rom_en;
   logic [ADDR_W-1:0]       rom_addr;
   logic [31:0]             rom_data;
   logic [N_IN*DATA_W-1:0]  in_ports;
   logic [N_OUT*DATA_W-1:0] out_ports;
   logic                    busy;
   logic                    halted;
   logic                    err;

   modport master (
      output rom_en, rom_addr, out_ports, busy, halted, err,
      input  rom_data, in_ports
   );

   modport slave (
      input  rom_en, rom_addr, out_ports, busy, halted, err,
      output rom_data, in_ports
   );
endinterface

// File: rtl/ucode_sequencer.sv
// ROM-driven microcode interpreter: fetches 32-bit microinstructions from a synchronous ROM
// and executes them against packed input/output port banks (3 cycles per instruction).
module ucode_sequencer #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned N_IN       = 4,
   parameter int unsigned N_OUT      = 4,
   parameter int unsigned START_ADDR = 0
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              start,
   ucode_sequencer_if.master bus
);

   typedef enum logic [2:0] {StIdle, StFetch, StLoad, StExec, StHalted} state_e;

   localparam logic [3:0] OP_SETO = 4'd1;
   localparam logic [3:0] OP_COPY = 4'd2;
   localparam logic [3:0] OP_JMP  = 4'd3;
   localparam logic [3:0] OP_BEQ  = 4'd4;
   localparam logic [3:0] OP_BNE  = 4'd5;
   localparam logic [3:0] OP_WAIT = 4'd6;
   localparam logic [3:0] OP_HALT = 4'd7;

   state_e                  r_state, w_state_d;
   logic [ADDR_W-1:0]       r_pc, w_pc_d;
   logic [31:0]             r_ir, w_ir_d;
   logic [N_OUT*DATA_W-1:0] r_out, w_out_d;
   logic                    r_err, w_err_d;

   logic [3:0]        w_op, w_sel;
   logic [ADDR_W-1:0] w_addr, w_pc_inc;
   logic [DATA_W-1:0] w_imm, w_in_sel, w_in_cpy, w_wr_val;
   logic              w_illegal, w_wr_en, w_in_match;
   logic              w_unused_ir;

   assign w_op        = r_ir[31:28];
   assign w_sel       = r_ir[27:24];
   assign w_addr      = r_ir[12 +: ADDR_W];
   assign w_imm       = r_ir[DATA_W-1:0];
   assign w_pc_inc    = r_pc + ADDR_W'(1);
   assign w_unused_ir = ^r_ir;

   // Port lookups by constant-index loop so out-of-range selects never form a bad index.
   always_comb begin
      w_in_sel = '0;
      w_in_cpy = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (w_sel == 4'(i))     w_in_sel = bus.in_ports[i*DATA_W +: DATA_W];
         if (r_ir[3:0] == 4'(i)) w_in_cpy = bus.in_ports[i*DATA_W +: DATA_W];
      end
   end

   assign w_in_match = (w_in_sel == w_imm);

   always_comb begin
      w_illegal = 1'b0;
      unique case (w_op)
         OP_SETO:                 w_illegal = (32'(w_sel) >= N_OUT);
         OP_COPY:                 w_illegal = (32'(w_sel) >= N_OUT) || (32'(r_ir[3:0]) >= N_IN);
         OP_BEQ, OP_BNE, OP_WAIT: w_illegal = (32'(w_sel) >= N_IN);
         4'd0, OP_JMP, OP_HALT:   w_illegal = 1'b0;
         default:                 w_illegal = 1'b1;
      endcase
   end

   assign w_wr_en  = (r_state == StExec) && !w_illegal && ((w_op == OP_SETO) || (w_op == OP_COPY));
   assign w_wr_val = (w_op == OP_COPY) ? w_in_cpy : w_imm;

   always_comb begin
      w_out_d = r_out;
      for (int i = 0; i < int'(N_OUT); i++) begin
         if (w_wr_en && (w_sel == 4'(i))) w_out_d[i*DATA_W +: DATA_W] = w_wr_val;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      w_ir_d    = r_ir;
      w_err_d   = r_err;
      case (r_state)
         StIdle: begin
            if (start) begin
               w_pc_d    = ADDR_W'(START_ADDR);
               w_state_d = StFetch;
            end
         end
         StFetch: w_state_d = StLoad;
         StLoad: begin
            w_ir_d    = bus.rom_data;
            w_state_d = StExec;
         end
         StExec: begin
            w_state_d = StFetch;
            w_pc_d    = w_pc_inc;
            if (w_illegal) begin
               w_err_d   = 1'b1;
               w_state_d = StHalted;
               w_pc_d    = r_pc;
            end else begin
               case (w_op)
                  OP_JMP: w_pc_d = w_addr;
                  OP_BEQ: w_pc_d = w_in_match ? w_addr : w_pc_inc;
                  OP_BNE: w_pc_d = w_in_match ? w_pc_inc : w_addr;
                  OP_WAIT: begin
                     // Stall in EXEC, re-sampling the input every cycle.
                     if (!w_in_match) begin
                        w_state_d = StExec;
                        w_pc_d    = r_pc;
                     end
                  end
                  OP_HALT: begin
                     w_state_d = StHalted;
                     w_pc_d    = r_pc;
                  end
                  default: ;
               endcase
            end
         end
         StHalted: begin
            if (start) begin
               w_err_d   = 1'b0;
               w_pc_d    = ADDR_W'(START_ADDR);
               w_state_d = StFetch;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_state <= StIdle;
         r_pc    <= ADDR_W'(START_ADDR);
         r_ir    <= '0;
         r_out   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_pc    <= w_pc_d;
         r_ir    <= w_ir_d;
         r_out   <= w_out_d;
         r_err   <= w_err_d;
      end
   end

   assign bus.rom_en    = (r_state == StFetch);
   assign bus.rom_addr  = r_pc;
   assign bus.out_ports = r_out;
   assign bus.busy      = (r_state == StFetch) || (r_state == StLoad) || (r_state == StExec);
   assign bus.halted    = (r_state == StHalted);
   assign bus.err       = r_err;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: vector table, directed corner sequences, and random
// programs checked against an instruction-level interpreter.
module tb_ucode_sequencer;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   logic start = 1'b0;
   logic start5 = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] rom [4096];
   logic [31:0] rom5 [16];
   logic [7:0]  m_out [4];

   ucode_sequencer_if #(.ADDR_W(12), .DATA_W(8), .N_IN(4), .N_OUT(4)) bus ();
   ucode_sequencer_if #(.ADDR_W(4), .DATA_W(8), .N_IN(4), .N_OUT(4)) bus5 ();

   ucode_sequencer #(.ADDR_W(12), .DATA_W(8), .N_IN(4), .N_OUT(4), .START_ADDR(0)) dut (
      .clk(clk), .aresetn(aresetn), .start(start), .bus(bus)
   );

   ucode_sequencer #(.ADDR_W(4), .DATA_W(8), .N_IN(4), .N_OUT(4), .START_ADDR(15)) dut5 (
      .clk(clk), .aresetn(aresetn), .start(start5), .bus(bus5)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
   always @(posedge clk) if (bus5.rom_en) bus5.rom_data <= rom5[bus5.rom_addr];

   typedef struct {
      logic [31:0] instr;
      logic [31:0] inp;
      logic [31:0] exp_out;
      logic        exp_err;
      int          exp_cyc;
   } vec_t;

   vec_t vecs [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      start   = 1'b0;
      start5  = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) rom[i] = 32'h7000_0000;
   endtask

   // Pulse start and count edges until halted (bounded).
   task automatic run_prog(output int cyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (!bus.halted && cyc < 400) begin
         tick();
         cyc++;
      end
   endtask

   // Instruction-level interpreter: returns error flag and instructions executed.
   task automatic model_run(input logic [31:0] inp, output logic e_err, output int e_n);
      logic [11:0] pc;
      logic [31:0] w;
      logic [3:0]  op;
      int          sel;
      int          src;
      logic        done;
      logic        eq;
      pc = 12'd0;
      done = 1'b0;
      e_err = 1'b0;
      e_n = 0;
      while (!done && e_n < 200) begin
         w   = rom[pc];
         op  = w[31:28];
         sel = int'(w[27:24]);
         src = int'(w[3:0]);
         e_n++;
         case (op)
            4'd0: pc = pc + 12'd1;
            4'd1: begin
               if (sel < 4) begin m_out[sel] = w[7:0]; pc = pc + 12'd1; end
               else begin e_err = 1'b1; done = 1'b1; end
            end
            4'd2: begin
               if (sel < 4 && src < 4) begin m_out[sel] = inp[src*8 +: 8]; pc = pc + 12'd1; end
               else begin e_err = 1'b1; done = 1'b1; end
            end
            4'd3: pc = w[23:12];
            4'd4, 4'd5: begin
               if (sel < 4) begin
                  eq = (inp[sel*8 +: 8] == w[7:0]);
                  pc = (eq == (op == 4'd4)) ? w[23:12] : pc + 12'd1;
               end else begin e_err = 1'b1; done = 1'b1; end
            end
            4'd6: begin
               if (sel < 4) pc = pc + 12'd1;
               else begin e_err = 1'b1; done = 1'b1; end
            end
            4'd7: done = 1'b1;
            default: begin e_err = 1'b1; done = 1'b1; end
         endcase
      end
   endtask

   initial begin
      int cyc;
      int k;
      int sel;
      int tgt;
      logic [3:0] op;
      logic [11:0] imm;
      logic [31:0] inp;
      logic e_err;
      int e_n;
      logic [3:0] q[$];

      vecs[0]  = '{32'h1100_00A5, 32'h0000_0000, 32'h0000_A500, 1'b0, 7};
      vecs[1]  = '{32'h1300_01FF, 32'h0000_0000, 32'hFF00_0000, 1'b0, 7};
      vecs[2]  = '{32'h2000_0002, 32'h4433_2211, 32'h0000_0033, 1'b0, 7};
      vecs[3]  = '{32'h2300_0000, 32'h0000_00C7, 32'hC700_0000, 1'b0, 7};
      vecs[4]  = '{32'h1500_0011, 32'h0000_0000, 32'h0000_0000, 1'b1, 4};
      vecs[5]  = '{32'h2100_0007, 32'h0000_0000, 32'h0000_0000, 1'b1, 4};
      vecs[6]  = '{32'h5400_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4};
      vecs[7]  = '{32'hC000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4};
      vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 7};
      vecs[9]  = '{32'h3002_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 7};
      vecs[10] = '{32'h6900_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4};
      vecs[11] = '{32'h7000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 4};
      vecs[12] = '{32'h1000_0F3C, 32'h0000_0000, 32'h0000_003C, 1'b0, 7};

      bus.in_ports  = '0;
      bus5.in_ports = '0;
      clear_rom();
      for (int i = 0; i < 16; i++) rom5[i] = 32'h7000_0000;

      // Reset state
      do_reset();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_halted", 32'(bus.halted), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_rom_en", 32'(bus.rom_en), 32'd0);
      check("rst_out", bus.out_ports, 32'd0);
      check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);

      // Vector table: one instruction followed by HALT background
      for (int v = 0; v < 13; v++) begin
         do_reset();
         clear_rom();
         rom[0] = vecs[v].instr;
         bus.in_ports = vecs[v].inp;
         run_prog(cyc);
         check($sformatf("vec%0d_out", v), bus.out_ports, vecs[v].exp_out);
         check($sformatf("vec%0d_err", v), 32'(bus.err), 32'(vecs[v].exp_err));
         check($sformatf("vec%0d_cyc", v), 32'(cyc), 32'(vecs[v].exp_cyc));
      end

      // Output timing: written on the 4th edge after start
      do_reset();
      clear_rom();
      rom[0] = 32'h1100_00A5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("t1_out_before", bus.out_ports, 32'd0);
      tick();
      check("t1_out_edge4", bus.out_ports, 32'h0000_A500);
      tick();
      tick();
      check("t1_not_halted", 32'(bus.halted), 32'd0);
      tick();
      check("t1_halted", 32'(bus.halted), 32'd1);
      check("t1_err", 32'(bus.err), 32'd0);

      // Illegal opcode keeps outputs; restart clears err and refetches from START_ADDR
      rom[0] = 32'hC000_0000;
      run_prog(cyc);
      check("t4_err", 32'(bus.err), 32'd1);
      check("t4_halted", 32'(bus.halted), 32'd1);
      check("t4_out_kept", bus.out_ports, 32'h0000_A500);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_err_clr", 32'(bus.err), 32'd0);
      check("t4_refetch_en", 32'(bus.rom_en), 32'd1);
      check("t4_refetch_addr", 32'(bus.rom_addr), 32'd0);
      for (int c = 0; c < 10 && !bus.halted; c++) tick();

      // WAIT stalls until the input matches
      do_reset();
      clear_rom();
      rom[0] = 32'h6200_003C;
      bus.in_ports = 32'h0000_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 22; c++) tick();
      check("t2_busy", 32'(bus.busy), 32'd1);
      check("t2_rom_en", 32'(bus.rom_en), 32'd0);
      bus.in_ports = 32'h003C_0000;
      tick();
      tick();
      tick();
      check("t2_halt_early", 32'(bus.halted), 32'd0);
      tick();
      check("t2_halted", 32'(bus.halted), 32'd1);

      // BEQ taken / not taken
      for (int t = 0; t < 2; t++) begin
         do_reset();
         clear_rom();
         rom[0]     = 32'h4001_0007;
         rom[12'h10] = 32'h1000_0001;
         bus.in_ports = (t == 0) ? 32'd7 : 32'd6;
         run_prog(cyc);
         check($sformatf("t3_out_%0d", t), bus.out_ports, (t == 0) ? 32'd0000_0001 : 32'd0);
         check($sformatf("t3_cyc_%0d", t), 32'(cyc), (t == 0) ? 32'd10 : 32'd7);
      end

      // Narrow PC wrap on a 4-bit instance starting at 15
      do_reset();
      rom5[15] = 32'h0000_0000;
      rom5[0]  = 32'h7000_0000;
      start5 = 1'b1;
      tick();
      start5 = 1'b0;
      for (int c = 0; c < 20 && !bus5.halted; c++) begin
         if (bus5.rom_en) q.push_back(bus5.rom_addr);
         tick();
      end
      check("t5_nfetch", 32'(q.size()), 32'd2);
      if (q.size() == 2) begin
         check("t5_addr0", 32'(q[0]), 32'd15);
         check("t5_addr1", 32'(q[1]), 32'd0);
      end
      check("t5_halted", 32'(bus5.halted), 32'd1);

      // Start while busy is ignored; reset during EXEC beats start and blocks the write
      do_reset();
      clear_rom();
      rom[0] = 32'h1000_0055;
      start = 1'b1;
      tick();
      tick();
      check("t6_no_restart", 32'(bus.rom_en), 32'd0);
      tick();
      start = 1'b0;
      tick();
      check("t6_out", bus.out_ports, 32'h0000_0055);
      for (int c = 0; c < 10 && !bus.halted; c++) tick();
      rom[0] = 32'h1200_0099;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      aresetn = 1'b0;
      start = 1'b1;
      tick();
      check("t6_rst_out", bus.out_ports, 32'd0);
      check("t6_rst_busy", 32'(bus.busy), 32'd0);
      check("t6_rst_halted", 32'(bus.halted), 32'd0);
      check("t6_rst_en", 32'(bus.rom_en), 32'd0);
      aresetn = 1'b1;
      start = 1'b0;
      tick();
      tick();
      check("t6_idle", 32'(bus.busy), 32'd0);
      check("t6_idle_out", bus.out_ports, 32'd0);

      // Random forward-branching programs against the interpreter
      do_reset();
      for (int it = 0; it < 25; it++) begin
         clear_rom();
         inp = $urandom;
         for (int a = 0; a < 16; a++) begin
            k   = $urandom_range(0, 99);
            sel = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            tgt = $urandom_range(a + 1, 16);
            imm = 12'($urandom_range(0, 4095));
            if (k < 12)      op = 4'd0;
            else if (k < 30) op = 4'd1;
            else if (k < 48) op = 4'd2;
            else if (k < 56) op = 4'd3;
            else if (k < 68) op = 4'd4;
            else if (k < 80) op = 4'd5;
            else if (k < 90) op = 4'd6;
            else if (k < 95) op = 4'd7;
            else             op = 4'($urandom_range(8, 15));
            if (op == 4'd2 && $urandom_range(0, 5) != 0) imm[3:0] = 4'($urandom_range(0, 3));
            if ((op == 4'd6 || ((op == 4'd4 || op == 4'd5) && $urandom_range(0, 1) == 1)) && sel < 4)
               imm[7:0] = inp[sel*8 +: 8];
            rom[a] = {op, 4'(sel), 12'(tgt), imm};
         end
         bus.in_ports = inp;
         model_run(inp, e_err, e_n);
         run_prog(cyc);
         check($sformatf("rnd%0d_out", it), bus.out_ports, {m_out[3], m_out[2], m_out[1], m_out[0]});
         check($sformatf("rnd%0d_err", it), 32'(bus.err), 32'(e_err));
         check($sformatf("rnd%0d_cyc", it), 32'(cyc), 32'(1 + 3 * e_n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
